// File: rtl/bram_port_arbiter.sv
// ============================================================================
//  Module      : bram_port_arbiter
//  Description : Shares one 512 x 16 byte-lane block RAM between an
//                instruction-fetch port (I) and a data load/store port (D).
//                D has priority; a starvation counter force-grants I after
//                STARVE_MAX consecutive refusals. A 1-deep response tag
//                routes the registered RAM read data back to the requester
//                that issued the access.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bram_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_i_req,
  input  logic [8:0]  i_i_addr,
  output logic        o_i_gnt,
  output logic        o_i_rvalid,
  output logic [15:0] o_i_rdata,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic        i_d_size,
  input  logic [9:0]  i_d_addr,
  input  logic [15:0] i_d_wdata,
  output logic        o_d_gnt,
  output logic        o_d_rvalid,
  output logic [15:0] o_d_rdata,
  output logic        o_d_err,
  output logic        o_bram_en,
  output logic        o_bram_we_h,
  output logic        o_bram_we_l,
  output logic [8:0]  o_bram_addr,
  output logic [7:0]  o_bram_din_h,
  output logic [7:0]  o_bram_din_l,
  input  logic [7:0]  i_bram_dout_h,
  input  logic [7:0]  i_bram_dout_l
);

  localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

  // Starvation counter and response tag
  logic [3:0] starve_q, starve_d;
  logic       tag_valid_q, tag_valid_d;
  logic       tag_own_d_q, tag_own_d_d;   // 1 = response belongs to D
  logic       tag_byte_q,  tag_byte_d;
  logic       tag_lane_q,  tag_lane_d;    // 1 = high byte lane
  logic       tag_err_q,   tag_err_d;
  logic       tag_we_q,    tag_we_d;      // writes answer with zero data

  logic force_i;
  logic i_gnt;
  logic d_gnt;
  logic d_mis;
  logic d_rsp;

  // Grant decision: D has priority unless I has been refused long enough
  always_comb begin
    force_i = i_i_req && (starve_q == c_starve_max);
    d_gnt   = i_rst_n && i_d_req && !force_i;
    i_gnt   = i_rst_n && i_i_req && !d_gnt;
    d_mis   = i_d_size && i_d_addr[0];
    o_i_gnt = i_gnt;
    o_d_gnt = d_gnt;
  end

  // Next state of the starvation counter and the response tag
  always_comb begin
    starve_d = 4'd0;
    if (i_i_req && !i_gnt) begin
      starve_d = (starve_q == c_starve_max) ? starve_q : starve_q + 4'd1;
    end
    tag_valid_d = i_gnt || d_gnt;
    tag_own_d_d = d_gnt;
    tag_byte_d  = d_gnt && !i_d_size;
    tag_lane_d  = i_d_addr[0];
    tag_err_d   = d_gnt && d_mis;
    tag_we_d    = d_gnt && i_d_we;
  end

  // RAM drive: only a legal grant touches the RAM, everything else is zero
  always_comb begin
    o_bram_en    = 1'b0;
    o_bram_we_h  = 1'b0;
    o_bram_we_l  = 1'b0;
    o_bram_addr  = 9'd0;
    o_bram_din_h = 8'd0;
    o_bram_din_l = 8'd0;
    if (i_gnt) begin
      o_bram_en   = 1'b1;
      o_bram_addr = i_i_addr;
    end else if (d_gnt && !d_mis) begin
      o_bram_en   = 1'b1;
      o_bram_addr = i_d_addr[9:1];
      if (i_d_we) begin
        if (i_d_size) begin
          o_bram_we_h  = 1'b1;
          o_bram_we_l  = 1'b1;
          o_bram_din_h = i_d_wdata[15:8];
          o_bram_din_l = i_d_wdata[7:0];
        end else begin
          // A byte store replicates the byte on both lanes; the enable picks one
          o_bram_we_h  = i_d_addr[0];
          o_bram_we_l  = !i_d_addr[0];
          o_bram_din_h = i_d_wdata[7:0];
          o_bram_din_l = i_d_wdata[7:0];
        end
      end
    end
  end

  // State registers; reset drops any in-flight response
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_q    <= 4'd0;
      tag_valid_q <= 1'b0;
      tag_own_d_q <= 1'b0;
      tag_byte_q  <= 1'b0;
      tag_lane_q  <= 1'b0;
      tag_err_q   <= 1'b0;
      tag_we_q    <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      tag_valid_q <= tag_valid_d;
      tag_own_d_q <= tag_own_d_d;
      tag_byte_q  <= tag_byte_d;
      tag_lane_q  <= tag_lane_d;
      tag_err_q   <= tag_err_d;
      tag_we_q    <= tag_we_d;
    end
  end

  // Response routing from the tag and the RAM's registered read data
  always_comb begin
    d_rsp      = tag_valid_q && tag_own_d_q;
    o_i_rvalid = tag_valid_q && !tag_own_d_q;
    o_i_rdata  = o_i_rvalid ? {i_bram_dout_h, i_bram_dout_l} : 16'd0;
    o_d_rvalid = d_rsp;
    o_d_err    = d_rsp && tag_err_q;
    o_d_rdata  = 16'd0;
    if (d_rsp && !tag_err_q && !tag_we_q) begin
      if (tag_byte_q) begin
        o_d_rdata = {8'h00, (tag_lane_q ? i_bram_dout_h : i_bram_dout_l)};
      end else begin
        o_d_rdata = {i_bram_dout_h, i_bram_dout_l};
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
// ============================================================================
//  Module      : tb_bram_port_arbiter
//  Description : Self-checking bench for bram_port_arbiter with a byte-level
//                memory reference model and a response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bram_port_arbiter;

  localparam int STARVE_MAX = 4;

  typedef struct {
    int          due;
    logic [15:0] data;
    logic        err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [8:0]  i_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic        d_size = 1'b0;
  logic [9:0]  d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, d_err;
  logic [15:0] i_rdata, d_rdata;
  logic        b_en, b_we_h, b_we_l;
  logic [8:0]  b_addr;
  logic [7:0]  b_din_h, b_din_l;
  logic [7:0]  b_dout_h = '0;
  logic [7:0]  b_dout_l = '0;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    refused = 0;
  bit    g_ig, g_dg;
  resp_t exp_i[$];
  resp_t exp_d[$];
  logic [7:0]  ref_mem [0:1023];
  logic [15:0] ram [0:511];

  always #5 clk = ~clk;

  bram_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_i_req(i_req), .i_i_addr(i_addr), .o_i_gnt(i_gnt),
    .o_i_rvalid(i_rvalid), .o_i_rdata(i_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_size(d_size), .i_d_addr(d_addr),
    .i_d_wdata(d_wdata), .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid),
    .o_d_rdata(d_rdata), .o_d_err(d_err),
    .o_bram_en(b_en), .o_bram_we_h(b_we_h), .o_bram_we_l(b_we_l),
    .o_bram_addr(b_addr), .o_bram_din_h(b_din_h), .o_bram_din_l(b_din_l),
    .i_bram_dout_h(b_dout_h), .i_bram_dout_l(b_dout_l)
  );

  function automatic logic [15:0] init_word(input int w);
    if (w == 5) return 16'hBEEF;
    return 16'(w * 40503) ^ 16'h5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Block RAM model: byte-lane writes, 1-cycle registered read
  initial begin
    for (int w = 0; w < 512; w++) ram[w] = init_word(w);
    forever begin
      @(posedge clk);
      if (b_en) begin
        b_dout_h <= ram[b_addr][15:8];
        b_dout_l <= ram[b_addr][7:0];
        if (b_we_h) ram[b_addr][15:8] = b_din_h;
        if (b_we_l) ram[b_addr][7:0]  = b_din_l;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle, a response is due exactly when the scoreboard says so
  always @(negedge clk) begin
    bit    due_i, due_d;
    resp_t r;
    due_i = (exp_i.size() != 0) && (exp_i[0].due == cyc);
    due_d = (exp_d.size() != 0) && (exp_d[0].due == cyc);
    check("i_rvalid", 32'(i_rvalid), 32'(due_i));
    check("d_rvalid", 32'(d_rvalid), 32'(due_d));
    if (due_i) begin
      r = exp_i.pop_front();
      check("i_rdata", 32'(i_rdata), 32'(r.data));
    end
    if (due_d) begin
      r = exp_d.pop_front();
      check("d_rdata", 32'(d_rdata), 32'(r.data));
      check("d_err", 32'(d_err), 32'(r.err));
    end
  end

  // One cycle of stimulus: drive, predict grants and RAM drive, log responses
  task automatic drive_cycle(input bit ir, input logic [8:0] ia, input bit dr,
                             input bit dwe, input bit dsz, input logic [9:0] da,
                             input logic [15:0] dwd, input bit rst_after);
    bit          eig, edg, mis, cmp_din;
    logic        e_en, e_wh, e_wl;
    logic [8:0]  e_addr;
    logic [7:0]  e_dh, e_dl;
    logic [15:0] rd;
    int          b;
    i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_size = dsz;
    d_addr = da; d_wdata = dwd;
    #4;
    eig = ir && (!dr || refused == STARVE_MAX);
    edg = dr && !eig;
    e_en = 0; e_wh = 0; e_wl = 0; e_addr = 0; e_dh = 0; e_dl = 0; cmp_din = 1;
    if (eig) begin
      e_en = 1; e_addr = ia; cmp_din = 0;
      exp_i.push_back('{cyc + 1, {ref_mem[2*ia+1], ref_mem[2*ia]}, 1'b0});
    end else if (edg) begin
      mis = dsz && da[0];
      b = int'(da);
      if (mis) begin
        exp_d.push_back('{cyc + 1, 16'h0000, 1'b1});
      end else begin
        e_en = 1; e_addr = da[9:1];
        if (dwe) begin
          if (dsz) begin
            e_wh = 1; e_wl = 1; e_dh = dwd[15:8]; e_dl = dwd[7:0];
            ref_mem[b] = dwd[7:0]; ref_mem[b+1] = dwd[15:8];
          end else begin
            e_wh = da[0]; e_wl = !da[0]; e_dh = dwd[7:0]; e_dl = dwd[7:0];
            ref_mem[b] = dwd[7:0];
          end
          exp_d.push_back('{cyc + 1, 16'h0000, 1'b0});
        end else begin
          cmp_din = 0;
          rd = dsz ? {ref_mem[b+1], ref_mem[b]} : {8'h00, ref_mem[b]};
          exp_d.push_back('{cyc + 1, rd, 1'b0});
        end
      end
    end
    check("i_gnt", 32'(i_gnt), 32'(eig));
    check("d_gnt", 32'(d_gnt), 32'(edg));
    check("bram_ctl", 32'({b_en, b_we_h, b_we_l, b_addr}), 32'({e_en, e_wh, e_wl, e_addr}));
    if (cmp_din) check("bram_din", 32'({b_din_h, b_din_l}), 32'({e_dh, e_dl}));
    if (ir && !eig) refused = (refused == STARVE_MAX) ? refused : refused + 1;
    else refused = 0;
    g_ig = eig; g_dg = edg;
    @(posedge clk);
    if (rst_after) begin
      #1;
      rst_n = 0;
      exp_i.delete(); exp_d.delete(); refused = 0;
      #1;
      check("rst_outs_now", 32'(|{i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
            d_err, b_en, b_we_h, b_we_l, b_addr, b_din_h, b_din_l}), 32'd0);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    drive_cycle(0, 9'd0, 0, 0, 0, 10'd0, 16'd0, 0);
  endtask

  task automatic both_streaming(input int n);
    for (int k = 0; k < n; k++) begin
      drive_cycle(1, 9'(k * 7), 1, 0, 1, 10'(k * 4), 16'd0, 0);
      check("starve_pattern", 32'(g_ig), 32'((k % 5) == 4));
    end
  endtask

  initial begin
    bit          pi, pd, pwe, psz;
    logic [8:0]  pia;
    logic [9:0]  pda;
    logic [15:0] pwd;
    for (int w = 0; w < 512; w++) begin
      logic [15:0] v;
      v = init_word(w);
      ref_mem[2*w] = v[7:0];
      ref_mem[2*w+1] = v[15:8];
    end
    // Reset: requests present but nothing may be granted or driven
    i_req = 1; d_req = 1; d_we = 1;
    #3;
    check("reset_outs", 32'(|{i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
          d_err, b_en, b_we_h, b_we_l, b_addr, b_din_h, b_din_l}), 32'd0);
    @(negedge clk); @(negedge clk);
    i_req = 0; d_req = 0; d_we = 0;
    rst_n = 1;
    idle();

    // I-only read of the BEEF word
    drive_cycle(1, 9'h005, 0, 0, 0, 10'd0, 16'd0, 0);
    idle();
    // Byte store to the high lane, then read back both lanes
    drive_cycle(0, 9'd0, 1, 1, 0, 10'h00B, 16'h5AA5, 0);
    drive_cycle(0, 9'd0, 1, 0, 0, 10'h00B, 16'd0, 0);
    drive_cycle(0, 9'd0, 1, 0, 0, 10'h00A, 16'd0, 0);
    // Misaligned halfword store, then confirm the word is untouched
    drive_cycle(0, 9'd0, 1, 1, 1, 10'h003, 16'h1234, 0);
    drive_cycle(0, 9'd0, 1, 0, 1, 10'h002, 16'd0, 0);
    idle();
    // Continuous contention: 4 D grants then a forced I grant, repeating
    both_streaming(15);
    idle();
    // Back-to-back halfword D reads of words 0, 1, 2
    for (int k = 0; k < 3; k++) drive_cycle(0, 9'd0, 1, 0, 1, 10'(k * 2), 16'd0, 0);
    idle();
    // Reset right after a D read grant: response dropped, counter cleared
    drive_cycle(1, 9'h010, 1, 0, 1, 10'h020, 16'd0, 1);
    i_req = 1; d_req = 1;
    #4;
    check("rst_gnt_blocked", 32'({i_gnt, d_gnt}), 32'd0);
    @(negedge clk);
    rst_n = 1;
    idle();
    both_streaming(10);
    idle();

    // Randomized traffic; each requester holds its request until granted
    pi = 0; pd = 0; pwe = 0; psz = 0; pia = '0; pda = '0; pwd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pi && $urandom_range(0, 3) != 0) begin
        pi = 1; pia = 9'($urandom);
      end
      if (!pd && $urandom_range(0, 3) != 0) begin
        pd = 1; pwe = 1'($urandom); psz = 1'($urandom);
        pda = 10'($urandom_range(0, 63)); pwd = 16'($urandom);
      end
      drive_cycle(pi, pia, pd, pwe, psz, pda, pwd, 0);
      if (g_ig) pi = 0;
      if (g_dg) pd = 0;
    end
    idle();
    idle();
    check("drain_i", 32'(exp_i.size()), 32'd0);
    check("drain_d", 32'(exp_d.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one 1 KB byte-enabled block RAM (512 x 16, separate high/low byte lanes, 1-cycle registered read) between an instruction-fetch port (I) and a data load/store port (D).
- Arbitrates per cycle, drives the RAM enable, byte write-enables, word address and write data, then routes the registered read data back to the requester that issued.
- Sits between the core's fetch/LSU stages and the RAM.

Parameters:
- STARVE_MAX, 4, consecutive cycles I may be refused while requesting before it is force-granted (1..15).

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_i_req  input  1  I request valid (read-only halfword).
- i_i_addr  input  9  I word address [9:1].
- o_i_gnt  output  1  I request accepted this cycle (combinational).
- o_i_rvalid  output  1  I read data valid.
- o_i_rdata  output  16  I read data.
- i_d_req  input  1  D request valid.
- i_d_we  input  1  D write (1) / read (0).
- i_d_size  input  1  0 = byte, 1 = halfword.
- i_d_addr  input  10  D byte address.
- i_d_wdata  input  16  D write data; a byte store uses [7:0].
- o_d_gnt  output  1  D request accepted this cycle (combinational).
- o_d_rvalid  output  1  D response valid (reads and writes).
- o_d_rdata  output  16  D read data.
- o_d_err  output  1  D response is a misalignment error.
- o_bram_en  output  1  RAM enable.
- o_bram_we_h  output  1  high-byte write enable.
- o_bram_we_l  output  1  low-byte write enable.
- o_bram_addr  output  9  RAM word address.
- o_bram_din_h  output  8  high-byte write data.
- o_bram_din_l  output  8  low-byte write data.
- i_bram_dout_h  input  8  RAM high-byte read data.
- i_bram_dout_l  input  8  RAM low-byte read data.

Behaviour:
- Byte order: little-endian. Byte address bit 0 = 0 selects the low lane; bit 0 = 1 selects the high lane.
- Grant rule:
  - D wins if i_d_req, unless starve_cnt == STARVE_MAX and i_i_req; in that case I wins.
  - At most one grant per cycle. A grant means accept; a requester holds req/addr/data stable until granted.
- starve_cnt (4 bit):
  - Increments when i_i_req is high and I is not granted.
  - Clears on an I grant or when i_i_req is low.
  - Saturates at STARVE_MAX.
- RAM drive:
  - o_bram_en = any grant to a legal access.
  - o_bram_addr = granted address [9:1].
  - Byte store: we_h = addr[0], we_l = ~addr[0]; both lanes carry wdata[7:0].
  - Halfword store: both write enables set; din_h = wdata[15:8], din_l = wdata[7:0].
  - Reads and I: both write enables low.
  - All RAM outputs are 0 when there is no legal grant.
- Misalignment: a D halfword with addr[0] = 1 is still granted but does not drive the RAM (en = 0, write enables = 0). Its response has o_d_err = 1 and o_d_rdata = 0.
- Response pipeline: registered tag {owner I/D, byte, lane, err, valid}.
  - Exactly one response per grant, 1 cycle after the grant, as a 1-cycle pulse on the owner's rvalid.
  - Writes respond with rdata = 0.
  - Halfword read: rdata = {dout_h, dout_l}.
  - Byte read: rdata = {8'h00, selected lane}.
  - Back-to-back grants give a response every cycle; no bubbles are inserted.
- Reset: asynchronous assert clears starve_cnt and the tag. All outputs are 0 during reset and on the first cycle after reset; no request is granted while i_rst_n = 0.
- Reset mid-operation: an in-flight response is dropped; the requester must reissue.
- Simultaneous I + D with starve_cnt < STARVE_MAX: D is granted and starve_cnt increments.
- Internal state:
  - FSM-free core: starve counter plus a 1-deep response register.
  - Counter states: COUNTING (0..STARVE_MAX-1), FORCE (== STARVE_MAX).
  - FORCE -> COUNTING (0) on an I grant or when i_i_req is low.

Test Plan:
- I-only read at addr 9'h005, RAM holds 16'hBEEF -> grant in cycle 0; cycle 1: o_i_rvalid = 1, o_i_rdata = 16'hBEEF, o_d_rvalid = 0.
- D byte store 0xA5 to byte addr 10'h00B -> en = 1, we_h = 1, we_l = 0, addr = 9'h005, din_h = 8'hA5. A following byte read of 10'h00B returns 16'h00A5; a following byte read of 10'h00A returns the unchanged low byte.
- D halfword store 16'h1234 at 10'h003 -> no RAM write. Next cycle: o_d_rvalid = 1, o_d_err = 1, o_d_rdata = 0; the word at 9'h001 is unchanged.
- I and D both requesting continuously, STARVE_MAX = 4 -> D granted 4 cycles, I granted on the 5th, then D again; the 5-cycle pattern repeats and responses are routed to the matching ports.
- Back-to-back D reads of 9'h000, 9'h001, 9'h002 -> three consecutive o_d_rvalid pulses with the correct data in order.
- i_rst_n pulled low one cycle after a D read grant -> no o_d_rvalid is ever produced, outputs are 0 at once, starve_cnt = 0 after release.
